// File: rtl/wb_dest_queue.sv
// wb_dest_queue: register-write destination resolver plus an in-order writeback queue.
//
// The destination is resolved combinationally from a 3-bit RegDst code and, on an
// accepted push, enqueued in a DEPTH-entry FIFO. Writeback retires entries from the
// head in order. A scoreboard compares two source registers against every pending
// entry so the control unit can stall on read-after-write hazards.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   select       RegDst code: 000 rt, 001 SP_ADDR, 010 RA_ADDR, 011 rd, 100 rs, else 0
//   in_rt        rt field
//   in_rd_field  instruction[15:0]; rd is taken from bits [10+ADDR_W:11]
//   in_rs        rs field
//   push_valid   request to enqueue the resolved destination
//   push_ready   queue can accept this cycle (also when full and being popped)
//   pop          writeback consumes the head entry (ignored when empty)
//   out_valid    head entry valid
//   out_addr     head destination address, 0 when empty
//   count        number of occupied entries
//   chk_rs       source A to check against pending entries
//   chk_rt       source B to check against pending entries
//   hazard_rs    chk_rs is nonzero and matches a pending entry
//   hazard_rt    chk_rt is nonzero and matches a pending entry
//   illegal_sel  sticky: a push was accepted with code 101..111
//
// Optional feature (macro WB_DEST_ZERO_DROP_EN): when defined, an accepted push whose
// resolved address is 0 is acknowledged but not stored.

module wb_dest_queue #(
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned SP_ADDR = 29,
   parameter int unsigned RA_ADDR = 31
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [2:0]               select,
   input  logic [ADDR_W-1:0]        in_rt,
   input  logic [15:0]              in_rd_field,
   input  logic [ADDR_W-1:0]        in_rs,
   input  logic                     push_valid,
   output logic                     push_ready,
   input  logic                     pop,
   output logic                     out_valid,
   output logic [ADDR_W-1:0]        out_addr,
   output logic [$clog2(DEPTH):0]   count,
   input  logic [ADDR_W-1:0]        chk_rs,
   input  logic [ADDR_W-1:0]        chk_rt,
   output logic                     hazard_rs,
   output logic                     hazard_rt,
   output logic                     illegal_sel
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              illegal_q, illegal_d;

   logic [ADDR_W-1:0] resolved;
   logic              sel_illegal;
   logic              push_acc;
   logic              do_pop;
   logic              do_wr;
   logic              drop;

   // Destination resolution
   always_comb begin
      resolved    = '0;
      sel_illegal = 1'b0;
      case (select)
         3'b000:  resolved = in_rt;
         3'b001:  resolved = ADDR_W'(SP_ADDR);
         3'b010:  resolved = ADDR_W'(RA_ADDR);
         3'b011:  resolved = in_rd_field[10+ADDR_W:11];
         3'b100:  resolved = in_rs;
         default: begin
            resolved    = '0;
            sel_illegal = 1'b1;
         end
      endcase
   end

`ifdef WB_DEST_ZERO_DROP_EN
   assign drop = (resolved == '0);
`else
   assign drop = 1'b0;
`endif

   assign out_valid = (count_q != '0);
   assign do_pop    = pop && out_valid;
   // A full queue still accepts when the head is leaving in the same cycle.
   assign push_ready = !reset && ((count_q < CW'(DEPTH)) || do_pop);
   assign push_acc   = push_valid && push_ready;
   assign do_wr      = push_acc && !drop;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      valid_d   = valid_q;
      illegal_d = illegal_q || (push_acc && sel_illegal);
      // Clear before set: when full, a simultaneous push reuses the slot being popped.
      if (do_pop) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + PW'(1);
      end
      if (do_wr) begin
         valid_d[wr_ptr_q] = 1'b1;
         wr_ptr_d          = wr_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_wr) - CW'(do_pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         valid_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
      end
   end

   // Storage is not reset; valid_q masks stale contents.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_q] <= resolved;
      end
   end

   assign out_addr    = out_valid ? mem[rd_ptr_q] : '0;
   assign count       = count_q;
   assign illegal_sel = illegal_q;

   // Scoreboard over stored entries only; register 0 never causes a hazard.
   always_comb begin
      hazard_rs = 1'b0;
      hazard_rt = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (valid_q[i] && (mem[i] == chk_rs) && (chk_rs != '0)) hazard_rs = 1'b1;
         if (valid_q[i] && (mem[i] == chk_rt) && (chk_rt != '0)) hazard_rt = 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_dest_queue.sv
module tb_wb_dest_queue;

   localparam int DEPTH = 4;
`ifdef WB_DEST_ZERO_DROP_EN
   localparam bit DROP = 1'b1;
`else
   localparam bit DROP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  select;
   logic [4:0]  in_rt;
   logic [15:0] in_rd_field;
   logic [4:0]  in_rs;
   logic        push_valid;
   logic        push_ready;
   logic        pop;
   logic        out_valid;
   logic [4:0]  out_addr;
   logic [2:0]  count;
   logic [4:0]  chk_rs;
   logic [4:0]  chk_rt;
   logic        hazard_rs;
   logic        hazard_rt;
   logic        illegal_sel;

   int checks = 0;
   int errors = 0;

   // Reference model: ordered list of pending destinations plus sticky flag.
   int mq[$];
   bit mill;

   always #5 clk = ~clk;

   wb_dest_queue #(
      .ADDR_W (5),
      .DEPTH  (DEPTH),
      .SP_ADDR(29),
      .RA_ADDR(31)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .select     (select),
      .in_rt      (in_rt),
      .in_rd_field(in_rd_field),
      .in_rs      (in_rs),
      .push_valid (push_valid),
      .push_ready (push_ready),
      .pop        (pop),
      .out_valid  (out_valid),
      .out_addr   (out_addr),
      .count      (count),
      .chk_rs     (chk_rs),
      .chk_rt     (chk_rt),
      .hazard_rs  (hazard_rs),
      .hazard_rt  (hazard_rt),
      .illegal_sel(illegal_sel)
   );

   function automatic int ref_resolve(int sel, int rt, int rdf, int rs);
      case (sel)
         0: return rt;
         1: return 29;
         2: return 31;
         3: return (rdf >> 11) & 31;
         4: return rs;
         default: return 0;
      endcase
   endfunction

   function automatic bit ref_hazard(int chk);
      if (chk == 0) return 1'b0;
      foreach (mq[i]) if (mq[i] == chk) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit ref_ready(bit p);
      return (mq.size() < DEPTH) || (p && mq.size() > 0);
   endfunction

   function automatic int ref_head();
      return (mq.size() > 0) ? mq[0] : 0;
   endfunction

   // Advance one clock and apply the same transaction to the model.
   task automatic tick();
      bit dpop, acc;
      int res;
      dpop = pop && (mq.size() > 0);
      acc  = push_valid && ref_ready(pop);
      res  = ref_resolve(select, in_rt, in_rd_field, in_rs);
      @(posedge clk);
      if (dpop) mq.delete(0);
      if (acc && !(DROP && res == 0)) mq.push_back(res);
      if (acc && select >= 3'd5) mill = 1'b1;
      #1;
   endtask

   task automatic idle();
      push_valid = 1'b0;
      pop        = 1'b0;
      select     = 3'd0;
      in_rt      = '0;
      in_rs      = '0;
      in_rd_field = '0;
      chk_rs     = '0;
      chk_rt     = '0;
   endtask

   task automatic push(int sel, int rt, int rdf, int rs);
      select      = 3'(sel);
      in_rt       = 5'(rt);
      in_rd_field = 16'(rdf);
      in_rs       = 5'(rs);
      push_valid  = 1'b1;
      tick();
      push_valid  = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      mq.delete();
      mill = 1'b0;
      #1;
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || out_addr !== 5'd0) begin
         errors++;
         $display("FAIL reset_state: count=%0d valid=%0b addr=%0d need 0 0 0", count, out_valid, out_addr);
      end
      checks++;
      if (illegal_sel !== 1'b0 || hazard_rs !== 1'b0 || hazard_rt !== 1'b0 || push_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_flags: ill=%0b hrs=%0b hrt=%0b rdy=%0b need 0 0 0 1", illegal_sel, hazard_rs, hazard_rt, push_ready);
      end
   endtask

   task automatic test_first_push();
      push(3, 0, 16'h5800, 0);
      chk_rs = 5'd11;
      chk_rt = 5'd0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_addr !== 5'd11 || count !== 3'd1) begin
         errors++;
         $display("FAIL first_push: valid=%0b addr=%0d count=%0d need 1 11 1", out_valid, out_addr, count);
      end
      checks++;
      if (hazard_rs !== 1'b1 || hazard_rt !== 1'b0) begin
         errors++;
         $display("FAIL first_hazard: hrs=%0b hrt=%0b need 1 0", hazard_rs, hazard_rt);
      end
      pop = 1'b1;
      tick();
      pop = 1'b0;
   endtask

   task automatic test_order_full();
      int exp[4] = '{8, 29, 31, 4};
      push(0, 8, 0, 0);
      push(1, 0, 0, 0);
      push(2, 0, 0, 0);
      push(4, 0, 0, 4);
      checks++;
      if (push_ready !== 1'b0 || count !== 3'd4) begin
         errors++;
         $display("FAIL full_ready: rdy=%0b count=%0d need 0 4", push_ready, count);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_addr !== 5'(exp[i]) || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pop_order[%0d]: addr=%0d valid=%0b need %0d 1", i, out_addr, out_valid, exp[i]);
         end
         pop = 1'b1;
         tick();
      end
      pop = 1'b0;
      checks++;
      if (count !== 3'd0 || out_addr !== 5'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL drained: count=%0d addr=%0d valid=%0b need 0 0 0", count, out_addr, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 4; i++) push(0, i, 0, 0);
      for (int i = 5; i <= 12; i++) begin
         select = 3'd0;
         in_rt = 5'(i);
         push_valid = 1'b1;
         pop = 1'b1;
         #1;
         checks++;
         if (push_ready !== 1'b1 || count !== 3'd4 || out_addr !== 5'(ref_head())) begin
            errors++;
            $display("FAIL wrap[%0d]: rdy=%0b count=%0d addr=%0d need 1 4 %0d", i, push_ready, count, out_addr, ref_head());
         end
         tick();
      end
      push_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_addr !== 5'(9 + i)) begin
            errors++;
            $display("FAIL wrap_drain[%0d]: addr=%0d need %0d", i, out_addr, 9 + i);
         end
         pop = 1'b1;
         tick();
      end
      pop = 1'b0;
   endtask

   task automatic test_empty_pop();
      pop = 1'b1;
      push(2, 0, 0, 0);
      pop = 1'b0;
      checks++;
      if (count !== 3'd1 || out_addr !== 5'd31) begin
         errors++;
         $display("FAIL empty_pushpop: count=%0d addr=%0d need 1 31", count, out_addr);
      end
      pop = 1'b1;
      tick();
      tick();
      pop = 1'b0;
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || out_addr !== 5'd0) begin
         errors++;
         $display("FAIL empty_pop: count=%0d valid=%0b addr=%0d need 0 0 0", count, out_valid, out_addr);
      end
   endtask

   task automatic test_illegal();
      push(6, 0, 0, 0);
      chk_rs = 5'd0;
      #1;
      checks++;
      if (illegal_sel !== 1'b1 || hazard_rs !== 1'b0) begin
         errors++;
         $display("FAIL illegal_set: ill=%0b hrs=%0b need 1 0", illegal_sel, hazard_rs);
      end
      checks++;
      if (count !== 3'(DROP ? 0 : 1) || out_addr !== 5'd0) begin
         errors++;
         $display("FAIL illegal_entry: count=%0d addr=%0d need %0d 0", count, out_addr, DROP ? 0 : 1);
      end
      pop = 1'b1;
      repeat (3) tick();
      pop = 1'b0;
      checks++;
      if (illegal_sel !== 1'b1 || count !== 3'd0) begin
         errors++;
         $display("FAIL illegal_sticky: ill=%0b count=%0d need 1 0", illegal_sel, count);
      end
   endtask

   task automatic test_async_reset();
      push(0, 7, 0, 0);
      push(4, 0, 0, 9);
      push(1, 0, 0, 0);
      chk_rs = 5'd7;
      chk_rt = 5'd29;
      #2 reset = 1'b1;
      #1;
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || out_addr !== 5'd0 || illegal_sel !== 1'b0 ||
          hazard_rs !== 1'b0 || hazard_rt !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: count=%0d valid=%0b addr=%0d ill=%0b hrs=%0b hrt=%0b need all 0",
                  count, out_valid, out_addr, illegal_sel, hazard_rs, hazard_rt);
      end
      mq.delete();
      mill = 1'b0;
      #2 reset = 1'b0;
      @(posedge clk);
      #1;
      push(0, 13, 0, 0);
      checks++;
      if (out_addr !== 5'd13 || count !== 3'd1 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL after_reset: addr=%0d count=%0d valid=%0b need 13 1 1", out_addr, count, out_valid);
      end
   endtask

   task automatic test_random();
      int pool[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 29, 31};
      for (int n = 0; n < 400; n++) begin
         select      = 3'($urandom_range(0, 9) > 8 ? $urandom_range(5, 7) : $urandom_range(0, 4));
         in_rt       = 5'($urandom_range(0, 7));
         in_rs       = 5'($urandom_range(0, 7));
         in_rd_field = 16'($urandom);
         in_rd_field[15:14] = 2'b00;
         push_valid  = 1'($urandom_range(0, 2) != 0);
         pop         = 1'($urandom_range(0, 1));
         chk_rs      = 5'(pool[$urandom_range(0, 9)]);
         chk_rt      = 5'(pool[$urandom_range(0, 9)]);
         #1;
         checks++;
         if (count !== 3'(mq.size()) || out_valid !== (mq.size() > 0) || out_addr !== 5'(ref_head()) ||
             push_ready !== ref_ready(pop) || hazard_rs !== ref_hazard(chk_rs) ||
             hazard_rt !== ref_hazard(chk_rt) || illegal_sel !== mill) begin
            errors++;
            $display("FAIL random[%0d]: cnt=%0d v=%0b a=%0d rdy=%0b hrs=%0b hrt=%0b ill=%0b need %0d %0b %0d %0b %0b %0b %0b",
                     n, count, out_valid, out_addr, push_ready, hazard_rs, hazard_rt, illegal_sel,
                     mq.size(), mq.size() > 0, ref_head(), ref_ready(pop), ref_hazard(chk_rs),
                     ref_hazard(chk_rt), mill);
         end
         tick();
      end
      idle();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_first_push();
      test_order_full();
      test_back_to_back();
      test_empty_pop();
      test_illegal();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
